// File: rtl/sudoku_dispatch.sv
// rtl/sudoku_dispatch.sv - round-robin multi-core puzzle dispatcher with in-order retire and watchdog
module sudoku_dispatch #(
  parameter int NUM_CORES      = 4,
  parameter int GRID           = 9,
  parameter int CELL_W         = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int PUZ_W         = GRID * GRID * CELL_W,
  localparam int CNT_W         = $clog2(NUM_CORES + 1)
) (
  input  logic                       clk_150,
  input  logic                       rst,
  input  logic                       go,
  input  logic                       puzzle_avail,
  input  logic [PUZ_W-1:0]           puzzle_in,
  output logic                       read_puzzle,
  output logic [PUZ_W-1:0]           core_puzzle,
  output logic [NUM_CORES-1:0]       core_load,
  output logic [NUM_CORES-1:0]       core_abort,
  output logic [NUM_CORES-1:0]       core_ack,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES*PUZ_W-1:0] core_result,
  input  logic                       out_wrfull,
  output logic                       out_wrreq,
  output logic [PUZ_W-1:0]           out_data,
  output logic                       out_give_up,
  output logic [CNT_W-1:0]           busy_count,
  output logic [15:0]                timeout_cnt
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CORES - 1);
  localparam logic [TW-1:0]    TLIM     = TW'(TIMEOUT_CYCLES - 1);
  localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_TIMED = 2'd3;

  logic [1:0]           slot_q  [NUM_CORES];
  logic [1:0]           slot_d  [NUM_CORES];
  logic [TW-1:0]        timer_q [NUM_CORES];
  logic [TW-1:0]        timer_d [NUM_CORES];
  logic [PTR_W-1:0]     dp_q, dp_d, rp_q, rp_d;
  logic [PUZ_W-1:0]     puzzle_q, puzzle_d;
  logic [NUM_CORES-1:0] load_q, load_d, abort_q, abort_d, ack_q, ack_d;
  logic                 wrreq_q, wrreq_d;
  logic [PUZ_W-1:0]     data_q, data_d;
  logic                 give_up_q, give_up_d;
  logic [CNT_W-1:0]     busy_q, busy_d;
  logic [15:0]          tcnt_q, tcnt_d;
  logic                 dispatch, retire;

  // A new puzzle goes only to the slot under dp; rst masks the pop so the FIFO is untouched in reset.
  assign dispatch = go & puzzle_avail & (slot_q[dp_q] == S_IDLE) & ~rst;

  // The oldest slot retires once finished; spacing writes two cycles apart absorbs wrfull latency.
  assign retire = ((slot_q[rp_q] == S_DONE) || (slot_q[rp_q] == S_TIMED)) & ~out_wrfull & ~wrreq_q;

  assign read_puzzle = dispatch;
  assign core_puzzle = puzzle_q;
  assign core_load   = load_q;
  assign core_abort  = abort_q;
  assign core_ack    = ack_q;
  assign out_wrreq   = wrreq_q;
  assign out_data    = data_q;
  assign out_give_up = give_up_q;
  assign busy_count  = busy_q;
  assign timeout_cnt = tcnt_q;

  // Next-state: slot progress and watchdog, then retire of the oldest slot, then dispatch to the next slot.
  always_comb begin
    slot_d    = slot_q;
    timer_d   = timer_q;
    dp_d      = dp_q;
    rp_d      = rp_q;
    puzzle_d  = puzzle_q;
    load_d    = '0;
    abort_d   = '0;
    ack_d     = '0;
    wrreq_d   = 1'b0;
    data_d    = '0;
    give_up_d = 1'b0;
    tcnt_d    = tcnt_q;
    busy_d    = '0;

    for (int i = 0; i < NUM_CORES; i++) begin
      if (slot_q[i] == S_RUN) begin
        timer_d[i] = timer_q[i] + TW'(1);
        if (core_done[i]) begin
          slot_d[i] = S_DONE;
        end else if (WDOG_EN && (timer_q[i] == TLIM)) begin
          slot_d[i]  = S_TIMED;
          abort_d[i] = 1'b1;
          if (tcnt_d != 16'hFFFF) begin
            tcnt_d = tcnt_d + 16'd1;
          end
        end
      end
    end

    if (retire) begin
      wrreq_d = 1'b1;
      if (slot_q[rp_q] == S_DONE) begin
        data_d      = core_result[int'(rp_q) * PUZ_W +: PUZ_W];
        ack_d[rp_q] = 1'b1;
      end else begin
        give_up_d = 1'b1;
      end
      slot_d[rp_q] = S_IDLE;
      rp_d         = (rp_q == LAST_PTR) ? '0 : rp_q + PTR_W'(1);
    end

    if (dispatch) begin
      slot_d[dp_q]  = S_RUN;
      timer_d[dp_q] = '0;
      load_d[dp_q]  = 1'b1;
      puzzle_d      = puzzle_in;
      dp_d          = (dp_q == LAST_PTR) ? '0 : dp_q + PTR_W'(1);
    end

    for (int i = 0; i < NUM_CORES; i++) begin
      if (slot_d[i] != S_IDLE) begin
        busy_d = busy_d + CNT_W'(1);
      end
    end
  end

  // State and registered outputs; reset returns every slot to IDLE with all strobes low.
  always_ff @(posedge clk_150 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_q[i]  <= S_IDLE;
        timer_q[i] <= '0;
      end
      dp_q      <= '0;
      rp_q      <= '0;
      puzzle_q  <= '0;
      load_q    <= '0;
      abort_q   <= '0;
      ack_q     <= '0;
      wrreq_q   <= 1'b0;
      data_q    <= '0;
      give_up_q <= 1'b0;
      busy_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_q[i]  <= slot_d[i];
        timer_q[i] <= timer_d[i];
      end
      dp_q      <= dp_d;
      rp_q      <= rp_d;
      puzzle_q  <= puzzle_d;
      load_q    <= load_d;
      abort_q   <= abort_d;
      ack_q     <= ack_d;
      wrreq_q   <= wrreq_d;
      data_q    <= data_d;
      give_up_q <= give_up_d;
      busy_q    <= busy_d;
      tcnt_q    <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_sudoku_dispatch.sv
// tb/tb_sudoku_dispatch.sv - self-checking bench for sudoku_dispatch
module tb_sudoku_dispatch;
  localparam int NC = 4;
  localparam int TO = 100;
  localparam int PW = 324;

  logic            clk_150 = 1'b0;
  logic            rst = 1'b1;
  logic            go = 1'b0;
  logic            puzzle_avail = 1'b0;
  logic [PW-1:0]   puzzle_in = '0;
  logic            read_puzzle;
  logic [PW-1:0]   core_puzzle;
  logic [NC-1:0]   core_load, core_abort, core_ack;
  logic [NC-1:0]   core_done = '0;
  logic [NC*PW-1:0] core_result;
  logic            out_wrfull = 1'b0;
  logic            out_wrreq;
  logic [PW-1:0]   out_data;
  logic            out_give_up;
  logic [2:0]      busy_count;
  logic [15:0]     timeout_cnt;

  sudoku_dispatch #(.NUM_CORES(NC), .GRID(9), .CELL_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk_150(clk_150), .rst(rst), .go(go), .puzzle_avail(puzzle_avail), .puzzle_in(puzzle_in),
    .read_puzzle(read_puzzle), .core_puzzle(core_puzzle), .core_load(core_load),
    .core_abort(core_abort), .core_ack(core_ack), .core_done(core_done), .core_result(core_result),
    .out_wrfull(out_wrfull), .out_wrreq(out_wrreq), .out_data(out_data),
    .out_give_up(out_give_up), .busy_count(busy_count), .timeout_cnt(timeout_cnt)
  );

  always #5 clk_150 = ~clk_150;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk_150) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Solver cores: low 16 bits of a puzzle give its solve time, 16'hFFFF never finishes; result is ~puzzle.
  logic [PW-1:0] lat [NC];
  int            cnt [NC];
  bit            act [NC];

  initial for (int k = 0; k < NC; k++) begin lat[k] = '0; cnt[k] = 0; act[k] = 0; end

  genvar g;
  for (g = 0; g < NC; g++) begin : g_res
    assign core_result[g*PW +: PW] = lat[g];
  end

  always @(negedge clk_150) begin
    for (int i = 0; i < NC; i++) begin
      if (rst || core_ack[i] || core_abort[i]) begin
        core_done[i] = 1'b0;
        act[i] = 0;
      end else if (core_load[i]) begin
        lat[i] = ~core_puzzle;
        core_done[i] = 1'b0;
        act[i] = 0;
        if (core_puzzle[15:0] == 16'd0) core_done[i] = 1'b1;
        else if (core_puzzle[15:0] != 16'hFFFF) begin cnt[i] = int'(core_puzzle[15:0]); act[i] = 1; end
      end else if (act[i]) begin
        cnt[i]--;
        if (cnt[i] == 0) begin core_done[i] = 1'b1; act[i] = 0; end
      end
    end
  end

  // Input FIFO
  logic [PW-1:0] feed_q[$];
  bit            rd_seen = 0;

  always @(posedge clk_150) begin
    #1;
    if (rd_seen && feed_q.size() > 0) void'(feed_q.pop_front());
    puzzle_avail = (feed_q.size() > 0);
    puzzle_in    = puzzle_avail ? feed_q[0] : '0;
  end

  // Reference model: puzzles in flight in arrival order, with the cycle each one becomes retirable
  typedef struct {
    logic [PW-1:0] puz;
    int            core;
    int            ld;
    int            rdy;
    bit            gu;
  } ent_t;

  ent_t mq[$];
  ent_t disp_ent;
  int   m_dp = 0;
  int   m_tcnt = 0;
  bit   ret_pend = 0;
  bit   disp_pend = 0;

  typedef struct { logic [PW-1:0] data; bit gu; int c; } wr_t;
  typedef struct { logic [NC-1:0] v; int c; } ev_t;
  wr_t           wlog[$];
  ev_t           loadlog[$];
  ev_t           abortlog[$];
  logic [NC-1:0] acklog[$];
  int            max_busy = 0;

  always @(negedge clk_150) begin : monitor
    ent_t          e, we;
    logic [NC-1:0] ex_load, ex_abort, ex_ack;
    bit            ex_wr, ex_rd, free;
    int            c, busy;
    logic [15:0]   d;
    if (cyc >= 1) begin
      c = cyc;
      if (rst) begin
        chk("rst_read_puzzle", read_puzzle, 0);
        chk("rst_core_puzzle", core_puzzle, 0);
        chk("rst_core_strobes", {core_load, core_abort, core_ack}, 0);
        chk("rst_out", {out_wrreq, out_give_up}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy_count, 0);
        chk("rst_tcnt", timeout_cnt, 0);
        mq.delete();
        m_dp = 0; m_tcnt = 0; ret_pend = 0; disp_pend = 0; rd_seen = 0;
      end else begin
        ex_wr = ret_pend;
        we = '{puz: '0, core: 0, ld: 0, rdy: 0, gu: 1'b0};
        if (ex_wr && mq.size() > 0) we = mq.pop_front();
        ex_load = '0;
        if (disp_pend) ex_load[disp_ent.core] = 1'b1;
        ex_abort = '0;
        busy = 0;
        foreach (mq[k]) begin
          if (mq[k].gu && (mq[k].ld + TO == c)) begin
            ex_abort[mq[k].core] = 1'b1;
            if (m_tcnt < 65535) m_tcnt++;
          end
          if (mq[k].ld <= c) busy++;
        end
        ex_ack = '0;
        if (ex_wr && !we.gu) ex_ack[we.core] = 1'b1;

        chk("out_wrreq", out_wrreq, ex_wr);
        chk("out_give_up", out_give_up, ex_wr && we.gu);
        if (ex_wr) chk("out_data", out_data, we.gu ? '0 : ~we.puz);
        chk("core_ack", core_ack, ex_ack);
        chk("core_load", core_load, ex_load);
        if (disp_pend) chk("core_puzzle", core_puzzle, disp_ent.puz);
        chk("core_abort", core_abort, ex_abort);
        chk("busy_count", busy_count, busy);
        chk("timeout_cnt", timeout_cnt, m_tcnt);

        if (out_wrreq) wlog.push_back('{data: out_data, gu: out_give_up, c: c});
        if (core_ack != '0) acklog.push_back(core_ack);
        if (core_load != '0) loadlog.push_back('{v: core_load, c: c});
        if (core_abort != '0) abortlog.push_back('{v: core_abort, c: c});
        if (int'(busy_count) > max_busy) max_busy = int'(busy_count);

        ret_pend = (mq.size() > 0) && (mq[0].rdy <= c) && !out_wrfull && !ex_wr;
        free = 1;
        foreach (mq[k]) if (mq[k].core == m_dp) free = 0;
        ex_rd = go && puzzle_avail && free;
        chk("read_puzzle", read_puzzle, ex_rd);
        disp_pend = ex_rd;
        if (ex_rd) begin
          d      = puzzle_in[15:0];
          e.puz  = puzzle_in;
          e.core = m_dp;
          e.ld   = c + 1;
          e.gu   = (d == 16'hFFFF) || (int'(d) >= TO);
          e.rdy  = e.gu ? e.ld + TO : e.ld + int'(d) + 1;
          mq.push_back(e);
          disp_ent = e;
          m_dp = (m_dp + 1) % NC;
        end
        rd_seen = read_puzzle;
      end
    end
  end

  function automatic logic [PW-1:0] mkpuz(input logic [15:0] dly);
    logic [PW-1:0] p;
    for (int k = 0; k < 10; k++) p[k*32 +: 32] = $urandom;
    p[PW-1:320] = 4'($urandom);
    p[15:0] = dly;
    return p;
  endfunction

  function automatic logic [PW-1:0] wdata(input int k);
    return (k < wlog.size()) ? wlog[k].data : '1;
  endfunction
  function automatic int wgu(input int k);
    return (k < wlog.size()) ? int'(wlog[k].gu) : -1;
  endfunction
  function automatic int wcyc(input int k);
    return (k < wlog.size()) ? wlog[k].c : -1000;
  endfunction
  function automatic int ackv(input int k);
    return (k < acklog.size()) ? int'(acklog[k]) : -1;
  endfunction
  function automatic int loadv(input int k);
    return (k < loadlog.size()) ? int'(loadlog[k].v) : -1;
  endfunction
  function automatic int loadc(input int k);
    return (k < loadlog.size()) ? loadlog[k].c : -1000;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_150);
    #1;
  endtask

  task automatic clear_logs();
    wlog.delete(); loadlog.delete(); abortlog.delete(); acklog.delete(); max_busy = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; go = 1'b0; out_wrfull = 1'b0; feed_q.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
    clear_logs();
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick(1);
      ok = (mq.size() == 0) && (feed_q.size() == 0) && !disp_pend;
    end
    chk("idle_within_budget", ok, 1);
  endtask

  logic [PW-1:0] pa, pb, pc, px, py, pz, pw, pe;
  logic [PW-1:0] pp[5];

  initial begin
    tick(3);
    chk("reset_busy", busy_count, 0);
    chk("reset_tcnt", timeout_cnt, 0);
    chk("reset_wrreq", out_wrreq, 0);
    rst = 1'b0;
    tick(1);
    clear_logs();

    // single puzzle, 10-cycle solve
    go = 1'b1;
    pa = mkpuz(16'd10);
    feed_q.push_back(pa);
    wait_idle(200);
    chk("t1_writes", wlog.size(), 1);
    chk("t1_data", wdata(0), ~pa);
    chk("t1_give_up", wgu(0), 0);
    chk("t1_load", loadv(0), 4'b0001);
    chk("t1_ack", ackv(0), 4'b0001);
    chk("t1_latency", wcyc(0) - loadc(0), 12);
    chk("t1_max_busy", max_busy, 1);
    chk("t1_busy_end", busy_count, 0);

    // out-of-order finish retires in arrival order
    reset_dut();
    go = 1'b1;
    pa = mkpuz(16'd60); pb = mkpuz(16'd40); pc = mkpuz(16'd20);
    feed_q.push_back(pa); feed_q.push_back(pb); feed_q.push_back(pc);
    wait_idle(300);
    chk("t2_writes", wlog.size(), 3);
    chk("t2_data0", wdata(0), ~pa);
    chk("t2_data1", wdata(1), ~pb);
    chk("t2_data2", wdata(2), ~pc);
    chk("t2_ack0", ackv(0), 4'b0001);
    chk("t2_ack1", ackv(1), 4'b0010);
    chk("t2_ack2", ackv(2), 4'b0100);

    // core1 never finishes: watchdog give-up
    reset_dut();
    go = 1'b1;
    px = mkpuz(16'd5); py = mkpuz(16'hFFFF);
    feed_q.push_back(px); feed_q.push_back(py);
    wait_idle(300);
    chk("t3_aborts", abortlog.size(), 1);
    chk("t3_abort_core", (abortlog.size() > 0) ? int'(abortlog[0].v) : -1, 4'b0010);
    chk("t3_abort_delay", ((abortlog.size() > 0) ? abortlog[0].c : 0) - loadc(1), 100);
    chk("t3_data0", wdata(0), ~px);
    chk("t3_gu1", wgu(1), 1);
    chk("t3_data1", wdata(1), '0);
    chk("t3_acks", acklog.size(), 1);
    chk("t3_tcnt", timeout_cnt, 1);

    // done on the last allowed cycle wins; one cycle later times out
    reset_dut();
    go = 1'b1;
    pz = mkpuz(16'd99); pw = mkpuz(16'd100);
    feed_q.push_back(pz); feed_q.push_back(pw);
    wait_idle(300);
    chk("t4_gu0", wgu(0), 0);
    chk("t4_data0", wdata(0), ~pz);
    chk("t4_gu1", wgu(1), 1);
    chk("t4_aborts", abortlog.size(), 1);
    chk("t4_tcnt", timeout_cnt, 1);

    // output backpressure with all cores finished
    reset_dut();
    out_wrfull = 1'b1;
    go = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pp[k] = mkpuz(16'(5 + k));
      feed_q.push_back(pp[k]);
    end
    tick(50);
    chk("t5_no_write", wlog.size(), 0);
    chk("t5_busy_full", busy_count, 4);
    chk("t5_no_read", read_puzzle, 0);
    chk("t5_fifo_left", feed_q.size(), 1);
    out_wrfull = 1'b0;
    wait_idle(200);
    chk("t5_writes", wlog.size(), 5);
    for (int k = 1; k < 4; k++) chk("t5_spacing", wcyc(k) - wcyc(k - 1), 2);
    for (int k = 0; k < 5; k++) chk("t5_order", wdata(k), ~pp[k]);

    // reset in the middle of three running solves
    reset_dut();
    go = 1'b1;
    for (int k = 0; k < 3; k++) feed_q.push_back(mkpuz(16'd50));
    tick(6);
    chk("t6_busy_before", busy_count, 3);
    rst = 1'b1;
    #1;
    chk("t6_rst_read", read_puzzle, 0);
    chk("t6_rst_busy", busy_count, 0);
    chk("t6_rst_strobes", {core_load, core_abort, core_ack, out_wrreq, out_give_up}, 0);
    feed_q.delete();
    tick(2);
    rst = 1'b0;
    clear_logs();
    pe = mkpuz(16'd4);
    feed_q.push_back(pe);
    wait_idle(200);
    chk("t6_restart_core0", loadv(0), 4'b0001);
    chk("t6_restart_data", wdata(0), ~pe);

    go = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
